// File: rtl/dallanma_cozucu.sv
// Branch resolution tracker: holds issued predictions in order, checks the oldest
// against the execute outcome, feeds predictor updates and raises redirects.
module dallanma_cozucu #(
    parameter int KUYRUK_DERINLIK = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        tahmin_gecerli_i,
    input  logic [31:0] tahmin_ps_i,
    input  logic        tahmin_atladi_i,
    input  logic [31:0] tahmin_hedef_i,
    output logic        tahmin_hazir_o,
    input  logic        cozum_gecerli_i,
    input  logic        cozum_atladi_i,
    input  logic [31:0] cozum_hedef_i,
    output logic        guncelle_gecerli_o,
    output logic        guncelle_atladi_o,
    output logic [31:0] guncelle_ps_o,
    output logic        yanlis_tahmin_o,
    output logic [31:0] duzeltilmis_ps_o,
    output logic [31:0] dogru_sayac_o,
    output logic [31:0] yanlis_sayac_o,
    output logic        bos_o,
    output logic        hata_o
);

    localparam int PTR_W = $clog2(KUYRUK_DERINLIK);
    localparam int CNT_W = $clog2(KUYRUK_DERINLIK + 1);
    localparam logic [CNT_W-1:0] DOLU = CNT_W'(KUYRUK_DERINLIK);

    // Entry storage (data only, never reset)
    logic [31:0] ps_q     [KUYRUK_DERINLIK];
    logic        atladi_q [KUYRUK_DERINLIK];
    logic [31:0] hedef_q  [KUYRUK_DERINLIK];

    // Queue control state
    logic [PTR_W-1:0] bas_p0;
    logic [PTR_W-1:0] son_p0;
    logic [CNT_W-1:0] sayi_p0;

    // Registered outputs, one cycle after resolution
    logic        guncelle_gecerli_p1;
    logic        guncelle_atladi_p1;
    logic [31:0] guncelle_ps_p1;
    logic        yanlis_tahmin_p1;
    logic [31:0] duzeltilmis_ps_p1;
    logic [31:0] dogru_sayac_p1;
    logic [31:0] yanlis_sayac_p1;
    logic        hata_p1;

    logic ekle;
    logic coz;
    logic yanlis;
    logic ekle_etkin;

    // Direction mismatch, or both taken but to different targets
    function automatic logic yanlis_mi(input logic t_at, input logic [31:0] t_hd,
                                       input logic c_at, input logic [31:0] c_hd);
        return (t_at != c_at) || (t_at && c_at && (t_hd != c_hd));
    endfunction

    // Where fetch must restart: actual target if taken, fall-through otherwise
    function automatic logic [31:0] duzeltme_ps(input logic c_at, input logic [31:0] c_hd,
                                                input logic [31:0] ps);
        return c_at ? c_hd : ps + 32'd4;
    endfunction

    assign tahmin_hazir_o = (sayi_p0 != DOLU);
    assign bos_o          = (sayi_p0 == '0);

    // Accept decisions; a mispredict kills any same-cycle enqueue (wrong path)
    always_comb begin
        ekle       = tahmin_gecerli_i && tahmin_hazir_o;
        coz        = cozum_gecerli_i && !bos_o;
        yanlis     = yanlis_mi(atladi_q[bas_p0], hedef_q[bas_p0], cozum_atladi_i, cozum_hedef_i);
        ekle_etkin = ekle && !(coz && yanlis);
    end

    // Write accepted predictions at the tail slot
    always_ff @(posedge clk_i) begin
        if (ekle_etkin) begin
            ps_q[son_p0]     <= tahmin_ps_i;
            atladi_q[son_p0] <= tahmin_atladi_i;
            hedef_q[son_p0]  <= tahmin_hedef_i;
        end
    end

    // Pointer/occupancy bookkeeping; mispredict flushes everything
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bas_p0  <= '0;
            son_p0  <= '0;
            sayi_p0 <= '0;
        end else if (coz && yanlis) begin
            bas_p0  <= son_p0;
            sayi_p0 <= '0;
        end else begin
            if (ekle_etkin) son_p0 <= son_p0 + 1'b1;
            if (coz)        bas_p0 <= bas_p0 + 1'b1;
            sayi_p0 <= sayi_p0 + CNT_W'(ekle_etkin) - CNT_W'(coz);
        end
    end

    // Update/redirect strobes, held data, counters and sticky error flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            guncelle_gecerli_p1 <= 1'b0;
            guncelle_atladi_p1  <= 1'b0;
            guncelle_ps_p1      <= '0;
            yanlis_tahmin_p1    <= 1'b0;
            duzeltilmis_ps_p1   <= '0;
            dogru_sayac_p1      <= '0;
            yanlis_sayac_p1     <= '0;
            hata_p1             <= 1'b0;
        end else begin
            guncelle_gecerli_p1 <= coz;
            yanlis_tahmin_p1    <= coz && yanlis;
            if (coz) begin
                guncelle_atladi_p1 <= cozum_atladi_i;
                guncelle_ps_p1     <= ps_q[bas_p0];
                if (yanlis) begin
                    duzeltilmis_ps_p1 <= duzeltme_ps(cozum_atladi_i, cozum_hedef_i, ps_q[bas_p0]);
                    yanlis_sayac_p1   <= yanlis_sayac_p1 + 32'd1;
                end else begin
                    dogru_sayac_p1    <= dogru_sayac_p1 + 32'd1;
                end
            end
            if (cozum_gecerli_i && bos_o) hata_p1 <= 1'b1;
        end
    end

    assign guncelle_gecerli_o = guncelle_gecerli_p1;
    assign guncelle_atladi_o  = guncelle_atladi_p1;
    assign guncelle_ps_o      = guncelle_ps_p1;
    assign yanlis_tahmin_o    = yanlis_tahmin_p1;
    assign duzeltilmis_ps_o   = duzeltilmis_ps_p1;
    assign dogru_sayac_o      = dogru_sayac_p1;
    assign yanlis_sayac_o     = yanlis_sayac_p1;
    assign hata_o             = hata_p1;

endmodule

// File: tb/tb_dallanma_cozucu.sv
// Directed bench for dallanma_cozucu: a cycle-by-cycle vector table plus
// hand-written sequences for pointer wrap and mid-stream reset.
module tb_dallanma_cozucu;

    logic        clk = 1'b0;
    logic        rst;
    logic        tg, tat, cg, cat;
    logic [31:0] tps, thd, chd;
    logic        hz, gg, gat, yt, bos, hata;
    logic [31:0] gps, dps, dog, yan;

    int compared = 0;
    int mismatched = 0;

    dallanma_cozucu #(.KUYRUK_DERINLIK(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .tahmin_gecerli_i(tg), .tahmin_ps_i(tps), .tahmin_atladi_i(tat), .tahmin_hedef_i(thd),
        .tahmin_hazir_o(hz),
        .cozum_gecerli_i(cg), .cozum_atladi_i(cat), .cozum_hedef_i(chd),
        .guncelle_gecerli_o(gg), .guncelle_atladi_o(gat), .guncelle_ps_o(gps),
        .yanlis_tahmin_o(yt), .duzeltilmis_ps_o(dps),
        .dogru_sayac_o(dog), .yanlis_sayac_o(yan),
        .bos_o(bos), .hata_o(hata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        tg;  logic [31:0] tps; logic tat; logic [31:0] thd;
        logic        cg;  logic cat; logic [31:0] chd;
        logic        gg;  logic gat; logic [31:0] gps; logic yt; logic [31:0] dps;
        logic [31:0] dog; logic [31:0] yan; logic bos; logic hz; logic hata;
    } vec_t;

    function automatic vec_t v(input logic i_tg, input logic [31:0] i_tps, input logic i_tat,
                               input logic [31:0] i_thd, input logic i_cg, input logic i_cat,
                               input logic [31:0] i_chd, input logic e_gg, input logic e_gat,
                               input logic [31:0] e_gps, input logic e_yt, input logic [31:0] e_dps,
                               input logic [31:0] e_dog, input logic [31:0] e_yan,
                               input logic e_bos, input logic e_hz, input logic e_hata);
        vec_t r;
        r.tg = i_tg; r.tps = i_tps; r.tat = i_tat; r.thd = i_thd;
        r.cg = i_cg; r.cat = i_cat; r.chd = i_chd;
        r.gg = e_gg; r.gat = e_gat; r.gps = e_gps; r.yt = e_yt; r.dps = e_dps;
        r.dog = e_dog; r.yan = e_yan; r.bos = e_bos; r.hz = e_hz; r.hata = e_hata;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        compared++;
        if (act !== exp_v) begin
            mismatched++;
            $display("FAIL %s got=%h expected=%h", nm, act, exp_v);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the rising edge
    task automatic step(input logic i_tg, input logic [31:0] i_tps, input logic i_tat,
                        input logic [31:0] i_thd, input logic i_cg, input logic i_cat,
                        input logic [31:0] i_chd);
        tg = i_tg; tps = i_tps; tat = i_tat; thd = i_thd;
        cg = i_cg; cat = i_cat; chd = i_chd;
        @(posedge clk);
        #1;
        tg = 1'b0; cg = 1'b0;
    endtask

    vec_t tbl [28];

    initial begin
        rst = 1'b1; tg = 0; tps = 0; tat = 0; thd = 0; cg = 0; cat = 0; chd = 0;
        //          tg tps       tat thd       cg cat chd        gg gat gps       yt dps       dog yan bos hz hata
        tbl[0]  = v(0, 0,        0, 0,        0, 0, 0,         0, 0, 0,        0, 0,        0, 0, 1, 1, 0);
        tbl[1]  = v(1, 32'h100,  1, 32'h200,  0, 0, 0,         0, 0, 0,        0, 0,        0, 0, 0, 1, 0);
        tbl[2]  = v(0, 0,        0, 0,        1, 1, 32'h200,   1, 1, 32'h100,  0, 0,        1, 0, 1, 1, 0);
        tbl[3]  = v(1, 32'h40,   0, 0,        0, 0, 0,         0, 1, 32'h100,  0, 0,        1, 0, 0, 1, 0);
        tbl[4]  = v(0, 0,        0, 0,        1, 1, 32'h80,    1, 1, 32'h40,   1, 32'h80,   1, 1, 1, 1, 0);
        tbl[5]  = v(1, 32'h50,   1, 32'h90,   0, 0, 0,         0, 1, 32'h40,   0, 32'h80,   1, 1, 0, 1, 0);
        tbl[6]  = v(0, 0,        0, 0,        1, 0, 0,         1, 0, 32'h50,   1, 32'h54,   1, 2, 1, 1, 0);
        tbl[7]  = v(1, 32'h2F0,  1, 32'h300,  0, 0, 0,         0, 0, 32'h50,   0, 32'h54,   1, 2, 0, 1, 0);
        tbl[8]  = v(0, 0,        0, 0,        1, 1, 32'h304,   1, 1, 32'h2F0,  1, 32'h304,  1, 3, 1, 1, 0);
        tbl[9]  = v(1, 32'h1000, 0, 0,        0, 0, 0,         0, 1, 32'h2F0,  0, 32'h304,  1, 3, 0, 1, 0);
        tbl[10] = v(1, 32'h1004, 0, 0,        0, 0, 0,         0, 1, 32'h2F0,  0, 32'h304,  1, 3, 0, 1, 0);
        tbl[11] = v(1, 32'h1008, 0, 0,        0, 0, 0,         0, 1, 32'h2F0,  0, 32'h304,  1, 3, 0, 1, 0);
        tbl[12] = v(1, 32'h100C, 0, 0,        0, 0, 0,         0, 1, 32'h2F0,  0, 32'h304,  1, 3, 0, 0, 0);
        tbl[13] = v(1, 32'h1010, 0, 0,        0, 0, 0,         0, 1, 32'h2F0,  0, 32'h304,  1, 3, 0, 0, 0);
        tbl[14] = v(1, 32'h2000, 0, 0,        1, 0, 0,         1, 0, 32'h1000, 0, 32'h304,  2, 3, 0, 1, 0);
        tbl[15] = v(0, 0,        0, 0,        1, 0, 0,         1, 0, 32'h1004, 0, 32'h304,  3, 3, 0, 1, 0);
        tbl[16] = v(0, 0,        0, 0,        1, 0, 0,         1, 0, 32'h1008, 0, 32'h304,  4, 3, 0, 1, 0);
        tbl[17] = v(0, 0,        0, 0,        1, 0, 0,         1, 0, 32'h100C, 0, 32'h304,  5, 3, 1, 1, 0);
        tbl[18] = v(1, 32'h500,  1, 32'h600,  0, 0, 0,         0, 0, 32'h100C, 0, 32'h304,  5, 3, 0, 1, 0);
        tbl[19] = v(1, 32'h504,  0, 0,        0, 0, 0,         0, 0, 32'h100C, 0, 32'h304,  5, 3, 0, 1, 0);
        tbl[20] = v(1, 32'h508,  0, 0,        0, 0, 0,         0, 0, 32'h100C, 0, 32'h304,  5, 3, 0, 1, 0);
        tbl[21] = v(1, 32'h50C,  0, 0,        1, 0, 0,         1, 0, 32'h500,  1, 32'h504,  5, 4, 1, 1, 0);
        tbl[22] = v(0, 0,        0, 0,        1, 0, 0,         0, 0, 32'h500,  0, 32'h504,  5, 4, 1, 1, 1);
        tbl[23] = v(1, 32'h700,  0, 0,        1, 0, 0,         0, 0, 32'h500,  0, 32'h504,  5, 4, 0, 1, 1);
        tbl[24] = v(0, 0,        0, 0,        1, 0, 0,         1, 0, 32'h700,  0, 32'h504,  6, 4, 1, 1, 1);
        tbl[25] = v(1, 32'h800,  0, 0,        0, 0, 0,         0, 0, 32'h700,  0, 32'h504,  6, 4, 0, 1, 1);
        tbl[26] = v(1, 32'h804,  0, 0,        1, 0, 0,         1, 0, 32'h800,  0, 32'h504,  7, 4, 0, 1, 1);
        tbl[27] = v(0, 0,        0, 0,        1, 0, 0,         1, 0, 32'h804,  0, 32'h504,  8, 4, 1, 1, 1);

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 28; i++) begin
            step(tbl[i].tg, tbl[i].tps, tbl[i].tat, tbl[i].thd, tbl[i].cg, tbl[i].cat, tbl[i].chd);
            chk($sformatf("r%0d_gg", i),   32'(gg),   32'(tbl[i].gg));
            chk($sformatf("r%0d_gat", i),  32'(gat),  32'(tbl[i].gat));
            chk($sformatf("r%0d_gps", i),  gps,       tbl[i].gps);
            chk($sformatf("r%0d_yt", i),   32'(yt),   32'(tbl[i].yt));
            chk($sformatf("r%0d_dps", i),  dps,       tbl[i].dps);
            chk($sformatf("r%0d_dog", i),  dog,       tbl[i].dog);
            chk($sformatf("r%0d_yan", i),  yan,       tbl[i].yan);
            chk($sformatf("r%0d_bos", i),  32'(bos),  32'(tbl[i].bos));
            chk($sformatf("r%0d_hz", i),   32'(hz),   32'(tbl[i].hz));
            chk($sformatf("r%0d_hata", i), 32'(hata), 32'(tbl[i].hata));
        end

        // Ten enqueue/resolve pairs; head/tail wrap past depth several times
        for (int i = 0; i < 10; i++) begin
            step(1, 32'h9000 + 32'(4 * i), 1, 32'hA000 + 32'(i), 0, 0, 0);
            chk($sformatf("w%0d_bos_after_enq", i), 32'(bos), 32'd0);
            step(0, 0, 0, 0, 1, 1, 32'hA000 + 32'(i));
            chk($sformatf("w%0d_gg", i),  32'(gg), 32'd1);
            chk($sformatf("w%0d_gat", i), 32'(gat), 32'd1);
            chk($sformatf("w%0d_gps", i), gps, 32'h9000 + 32'(4 * i));
            chk($sformatf("w%0d_yt", i),  32'(yt), 32'd0);
            chk($sformatf("w%0d_dog", i), dog, 32'd9 + 32'(i));
            chk($sformatf("w%0d_bos", i), 32'(bos), 32'd1);
        end

        // Reset with two entries pending discards them silently
        step(1, 32'hB000, 0, 0, 0, 0, 0);
        step(1, 32'hB004, 0, 0, 0, 0, 0);
        chk("rs_pending_bos", 32'(bos), 32'd0);
        rst = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        chk("rs_gg",   32'(gg),   32'd0);
        chk("rs_gat",  32'(gat),  32'd0);
        chk("rs_gps",  gps,       32'd0);
        chk("rs_yt",   32'(yt),   32'd0);
        chk("rs_dps",  dps,       32'd0);
        chk("rs_dog",  dog,       32'd0);
        chk("rs_yan",  yan,       32'd0);
        chk("rs_bos",  32'(bos),  32'd1);
        chk("rs_hz",   32'(hz),   32'd1);
        chk("rs_hata", 32'(hata), 32'd0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("rs_idle_gg", 32'(gg), 32'd0);
        step(0, 0, 0, 0, 1, 0, 0);
        chk("rs_resolve_gg",   32'(gg),   32'd0);
        chk("rs_resolve_hata", 32'(hata), 32'd1);
        chk("rs_resolve_dog",  dog,       32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/dallanma_cozucu.md
Name: dallanma_cozucu

Overview:
- Branch-resolution side of the predictor interface. Tracks every prediction issued at fetch in an in-order queue.
- Compares the oldest entry against the actual outcome from execute.
- Drives the predictor's update inputs (guncelle_gecerli/atladi/ps) and raises a mispredict redirect that flushes younger in-flight entries.
- Keeps correct/incorrect prediction counters.

Parameters:
- KUYRUK_DERINLIK, 4, queue depth in entries; power of two, 2..16.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  synchronous active-high reset
- tahmin_gecerli_i  input  1  fetch issued a predicted branch this cycle (enqueue request)
- tahmin_ps_i  input  32  PC of that branch
- tahmin_atladi_i  input  1  predicted taken
- tahmin_hedef_i  input  32  predicted target (predictor atlanan_ps)
- tahmin_hazir_o  output  1  queue not full; enqueue accepted only when high
- cozum_gecerli_i  input  1  execute resolved the oldest outstanding branch
- cozum_atladi_i  input  1  actual direction
- cozum_hedef_i  input  32  actual target (ignored if not taken)
- guncelle_gecerli_o  output  1  update strobe to predictor
- guncelle_atladi_o  output  1  actual direction for update
- guncelle_ps_o  output  32  PC of resolved branch
- yanlis_tahmin_o  output  1  mispredict pulse
- duzeltilmis_ps_o  output  32  redirect PC, valid with yanlis_tahmin_o
- dogru_sayac_o  output  32  correct predictions
- yanlis_sayac_o  output  32  mispredictions
- bos_o  output  1  queue empty
- hata_o  output  1  sticky: resolution arrived with empty queue

Behaviour:
- Reset (rst_i high at posedge):
  - queue emptied, counters 0, all registered outputs 0, hata_o 0.
  - tahmin_hazir_o=1, bos_o=1.
  - Reset mid-operation discards all entries with no update emitted.
- Queue:
  - Circular buffer, head/tail pointers of log2(KUYRUK_DERINLIK) bits wrapping modulo depth; separate occupancy count 0..KUYRUK_DERINLIK.
  - tahmin_hazir_o = (count != KUYRUK_DERINLIK); bos_o = (count == 0); both combinational from count.
  - Enqueue when tahmin_gecerli_i && tahmin_hazir_o. A request while full is dropped, with no other effect.
  - When full, enqueue is refused even if a resolution frees a slot in the same cycle.
- Resolution: accepted when cozum_gecerli_i && !bos_o, applied to the head entry.
  - Mispredict = (tahmin_atladi != cozum_atladi_i) || (both taken && tahmin_hedef != cozum_hedef_i).
  - Redirect PC = cozum_hedef_i if actual taken, else head PC + 4 (32-bit, wraps).
- Outputs are registered, one cycle latency. In the cycle after an accepted resolution:
  - guncelle_gecerli_o=1, guncelle_atladi_o=cozum_atladi_i, guncelle_ps_o=head PC.
  - yanlis_tahmin_o and duzeltilmis_ps_o set per the compare.
  - Both strobes are single-cycle pulses; otherwise they are 0 and the data outputs hold their last value.
- Correct prediction: dogru_sayac_o +1, head popped.
- Mispredict: yanlis_sayac_o +1; the whole queue is flushed (count=0, head=tail), since all younger entries are wrong-path. A same-cycle enqueue is also dropped.
- Counters wrap at 2^32.
- cozum_gecerli_i with empty queue: ignored, no update pulse, hata_o set until reset.
- Simultaneous enqueue and correct resolution with count strictly between 0 and full: both happen, count unchanged.
- Simultaneous enqueue and resolution at count 0: resolution is an error (hata_o), enqueue is accepted.

Test Plan:
- Reset, then enqueue PC 0x100 (predicted taken, target 0x200), resolve taken/0x200 -> next cycle guncelle_gecerli_o=1, guncelle_ps_o=0x100, yanlis_tahmin_o=0, dogru_sayac_o=1, bos_o=1.
- Enqueue PC 0x40 (predicted not taken), resolve taken/0x80 -> yanlis_tahmin_o=1, duzeltilmis_ps_o=0x80, yanlis_sayac_o=1; enqueue PC 0x50 (predicted taken), resolve not taken -> duzeltilmis_ps_o=0x54.
- Depth 4: enqueue 5 branches back-to-back -> tahmin_hazir_o=0 after the 4th, 5th dropped; 4 correct resolutions give 4 update pulses with PCs in enqueue order, bos_o=1.
- Enqueue 3; first resolves mispredicted while a 4th enqueue is requested the same cycle -> bos_o=1 next cycle, 4th dropped, later cozum_gecerli_i sets hata_o=1 with no update pulse.
- Interleave 10 enqueue/resolve pairs with pointers wrapping past depth; assert rst_i mid-stream with 2 entries pending -> all outputs/counters 0, tahmin_hazir_o=1, no pulse for the discarded entries.
- Direction correct but target wrong (predicted taken 0x300, actual taken 0x304) -> mispredict, duzeltilmis_ps_o=0x304, guncelle_atladi_o=1.
